// File: rtl/fsgn_pkg.sv
// Shared definitions for the floating-point sign-manipulation pipeline.
package fsgn_pkg;

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        FSGN_FABS   = 3'b000,
        FSGN_FNEG   = 3'b001,
        FSGN_FSGNJ  = 3'b010,
        FSGN_FSGNJN = 3'b011,
        FSGN_FSGNJX = 3'b100,
        FSGN_FCLASS = 3'b101
    } fsgn_op_e;

    // FCLASS mask bit positions
    localparam int unsigned CLS_W        = 10;
    localparam int unsigned CLS_NEG_INF  = 0;
    localparam int unsigned CLS_NEG_NORM = 1;
    localparam int unsigned CLS_NEG_SUB  = 2;
    localparam int unsigned CLS_NEG_ZERO = 3;
    localparam int unsigned CLS_POS_ZERO = 4;
    localparam int unsigned CLS_POS_SUB  = 5;
    localparam int unsigned CLS_POS_NORM = 6;
    localparam int unsigned CLS_POS_INF  = 7;
    localparam int unsigned CLS_SNAN     = 8;
    localparam int unsigned CLS_QNAN     = 9;

    // Result sign of a sign-manipulation op; independent of the data width,
    // the magnitude bits always come straight from x.
    function automatic logic sign_op(input fsgn_op_e op, input logic x_s, input logic z_s);
        logic s;
        case (op)
            FSGN_FABS:   s = 1'b0;
            FSGN_FNEG:   s = ~x_s;
            FSGN_FSGNJ:  s = z_s;
            FSGN_FSGNJN: s = ~z_s;
            FSGN_FSGNJX: s = x_s ^ z_s;
            default:     s = x_s;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/fsgn_stage.sv
// One stallable pipeline register: valid plus result payload.
module fsgn_stage #(
    parameter int unsigned W     = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_stall,
    input  logic             i_valid,
    input  logic [W-1:0]     i_y,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_ill,
    output logic             o_valid,
    output logic [W-1:0]     o_y,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_ill
);

    logic             r_valid;
    logic [W-1:0]     r_y;
    logic [TAG_W-1:0] r_tag;
    logic             r_ill;

    // Hold on stall; payload loads only with a real op so it stays zero after reset until one arrives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_y     <= '0;
            r_tag   <= '0;
            r_ill   <= 1'b0;
        end else if (!i_stall) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_y   <= i_y;
                r_tag <= i_tag;
                r_ill <= i_ill;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_y     = r_y;
    assign o_tag   = r_tag;
    assign o_ill   = r_ill;

endmodule

// File: rtl/fsgn_pipe.sv
// Pipelined FP sign-manipulation unit (FABS/FNEG/FSGNJ/FSGNJN/FSGNJX) with
// valid/ready backpressure, tag passthrough and a completed-op counter.
// Optional: define FSGN_FCLASS_EN to make op 101 return the FCLASS mask.
module fsgn_pipe
    import fsgn_pkg::*;
#(
    parameter int unsigned EXP_W   = 8,
    parameter int unsigned MAN_W   = 23,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                       sys_clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [OP_W-1:0]            op,
    input  logic [1+EXP_W+MAN_W-1:0]   x,
    input  logic [1+EXP_W+MAN_W-1:0]   z,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [1+EXP_W+MAN_W-1:0]   y,
    output logic [TAG_W-1:0]           out_tag,
    output logic                       out_illegal,
    output logic [CNT_W-1:0]           ops_count
);

    localparam int unsigned W = 1 + EXP_W + MAN_W;

    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("fsgn_pipe: LATENCY must be within 1..4");
    end

    fsgn_op_e         w_op;
    logic [W-1:0]     w_res;
    logic             w_ill;
    logic             w_stall;
    logic             w_unused_z;
    logic [CNT_W-1:0] r_ops_count;

    // Only the sign of z participates in any result
    assign w_unused_z = ^z[W-2:0];

`ifdef FSGN_FCLASS_EN
    if (W < CLS_W) begin : g_bad_width
        $error("fsgn_pipe: FCLASS needs a data width of at least 10 bits");
    end

    logic [CLS_W-1:0] w_cls;
    logic             w_exp_ones;
    logic             w_exp_zero;
    logic             w_man_zero;

    // Classify x into exactly one of the ten FCLASS categories
    always_comb begin
        w_cls      = '0;
        w_exp_ones = &x[W-2:MAN_W];
        w_exp_zero = ~|x[W-2:MAN_W];
        w_man_zero = ~|x[MAN_W-1:0];
        if (w_exp_ones) begin
            if (w_man_zero)       w_cls[x[W-1] ? CLS_NEG_INF : CLS_POS_INF] = 1'b1;
            else if (x[MAN_W-1])  w_cls[CLS_QNAN] = 1'b1;
            else                  w_cls[CLS_SNAN] = 1'b1;
        end else if (w_exp_zero) begin
            if (w_man_zero)       w_cls[x[W-1] ? CLS_NEG_ZERO : CLS_POS_ZERO] = 1'b1;
            else                  w_cls[x[W-1] ? CLS_NEG_SUB : CLS_POS_SUB] = 1'b1;
        end else begin
            w_cls[x[W-1] ? CLS_NEG_NORM : CLS_POS_NORM] = 1'b1;
        end
    end
`endif

    // Result computed ahead of stage 1; unknown ops pass x through flagged illegal
    always_comb begin
        w_op  = fsgn_op_e'(op);
        w_res = x;
        w_ill = 1'b0;
        case (w_op)
            FSGN_FABS, FSGN_FNEG, FSGN_FSGNJ, FSGN_FSGNJN, FSGN_FSGNJX:
                w_res = {sign_op(w_op, x[W-1], z[W-1]), x[W-2:0]};
`ifdef FSGN_FCLASS_EN
            FSGN_FCLASS:
                w_res = W'(w_cls);
`endif
            default:
                w_ill = 1'b1;
        endcase
    end

    // Whole pipe freezes while a result waits at the output; bubbles are kept
    assign w_stall  = out_valid & ~out_ready;
    assign in_ready = ~w_stall;

    logic             w_v   [0:LATENCY];
    logic [W-1:0]     w_y   [0:LATENCY];
    logic [TAG_W-1:0] w_tag [0:LATENCY];
    logic             w_il  [0:LATENCY];

    assign w_v[0]   = in_valid;
    assign w_y[0]   = w_res;
    assign w_tag[0] = in_tag;
    assign w_il[0]  = w_ill;

    for (genvar g = 0; g < LATENCY; g++) begin : g_stage
        fsgn_stage #(
            .W     (W),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk     (sys_clk),
            .rst     (rst),
            .i_stall (w_stall),
            .i_valid (w_v[g]),
            .i_y     (w_y[g]),
            .i_tag   (w_tag[g]),
            .i_ill   (w_il[g]),
            .o_valid (w_v[g+1]),
            .o_y     (w_y[g+1]),
            .o_tag   (w_tag[g+1]),
            .o_ill   (w_il[g+1])
        );
    end

    assign out_valid   = w_v[LATENCY];
    assign y           = w_y[LATENCY];
    assign out_tag     = w_tag[LATENCY];
    assign out_illegal = w_il[LATENCY];

    // Count completed output handshakes, wrapping naturally
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            r_ops_count <= '0;
        end else if (out_valid && out_ready) begin
            r_ops_count <= r_ops_count + CNT_W'(1);
        end
    end

    assign ops_count = r_ops_count;

endmodule
